instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Decode/issue stage between instruction fetch and the ALU/execute stage of the 16-bit CPU. It accepts raw 16-bit instructions from fetch over a valid/ready handshake and registers them into the IR' pipeline register. It produces the 6-bit encoded opcode, register addresses and write-back controls that execute consumes. It also inserts the load-use interlock bubble, discards wrong-path instructions on flush, and halts on STP.

## Interface
- LOAD_USE_BUBBLE, 1, 1 enables the one-cycle load-use interlock; 0 disables it (dec_valid is never masked).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_valid  in  1  fetch_instruction is valid.
- fetch_instruction  in  16  raw instruction word.
- fetch_ready  out  1  stage accepts fetch_instruction this cycle.
- flush  in  1  branch taken in execute; kill the held instruction and the current fetch word.
- exec_ready  in  1  execute accepts the decoded instruction.
- dec_valid  out  1  decoded outputs are valid.
- dec_instruction  out  16  IR' copy of the held word.
- dec_opcode  out  6  encoded opcode.
- dec_rs1_addr, dec_rs2_addr, dec_wr_addr  out  3 each  operand and destination register addresses.
- dec_wr_en  out  1  instruction writes dec_wr_addr.
- dec_wr2_en  out  1  MUL only: high half is written to (dec_wr_addr+1) mod 8.
- dec_is_branch  out  1  control-flow instruction.
- dec_illegal  out  1  opcode out of range.
- halted  out  1  stage is in HALT.
- issue_count  out  16  count of instructions transferred to execute; wraps.

## Operation
- Instruction fields:
  - raw = instr[15:10]
  - rd = instr[9:7] drives dec_wr_addr and dec_rs1_addr.
  - rs = instr[6:4] drives dec_rs2_addr.
  - instr[3:0] is the bit offset and passes through in dec_instruction.
- Opcode mapping:
  - raw 0x00–0x38: dec_opcode = raw.
  - raw 0x39–0x3F: dec_opcode = 6'h3F, dec_illegal=1, dec_wr_en=0, dec_wr2_en=0.
- dec_wr_en=1 for 0x03, 0x06–0x0E, 0x10–0x14, 0x17, 0x18, 0x1A, 0x1B, 0x1D–0x22, 0x25. GHA/GHS (0x15, 0x16) never write.
- dec_wr2_en=1 only for 0x21.
- Load class: 0x1A LOAD, 0x1B POP, 0x25 LDA.
- Branch class (dec_is_branch=1): 0x00, 0x01, 0x02, 0x23, 0x24, 0x26, 0x37, 0x38.
- Operand use:
  - uses_rs2 for 0x11–0x16, 0x19, 0x1C, 0x1D–0x21.
  - uses_rs1 for every legal opcode except 0x0A, 0x26–0x36.
- Holding register (out_valid plus decoded fields):
  - Loads when fetch_valid & fetch_ready.
  - Clears when transferred without a replacement.
- fetch_ready = (state==RUN) & ~flush & (~out_valid | (dec_valid & exec_ready)).
- Transfer = dec_valid & exec_ready. Each transfer increments issue_count modulo 2^16.
- Load-use interlock:
  - A transfer of a load-class instruction sets load_pending=1 and load_rd=rd. Both are cleared at the next edge.
  - hazard = LOAD_USE_BUBBLE & load_pending & out_valid & ((uses_rs1 & rd==load_rd) | (uses_rs2 & rs==load_rd)).
  - dec_valid = out_valid & ~hazard & (state==RUN). This gives exactly one bubble cycle.
- States:
  - RUN → HALT on transfer of STP (0x27).
  - HALT exits only on reset. In HALT, fetch_ready=0 and dec_valid=0, and flush is ignored.
- Flush (RUN state): out_valid←0 and load_pending←0 at the edge, and the fetch word is dropped. Flush has priority over a simultaneous capture. A transfer in the same cycle still counts.

## Timing
- Reset values:
  - All dec_* outputs are 0 and out_valid=0.
  - State = RUN, load_pending=0, issue_count=0, halted=0.
  - fetch_ready=1 immediately after reset deasserts.
- Decode latency is 1 cycle: an instruction accepted at edge t is presented with dec_valid from cycle t+1, unless masked by hazard.
- Throughput is one instruction per cycle when exec_ready=1 and there are no hazards.
- Outputs hold stable while dec_valid=1 and exec_ready=0.
- A load-use pair costs exactly one extra cycle. Non-dependent consumers cost none.
- halted rises the cycle after the STP transfer edge.
- Reset asserted mid-stream clears everything asynchronously. The held instruction is lost.

## Test plan
- Stream ADD r1,r2 (0x44A0), then INV r5 (0x1A80), with exec_ready=1 → dec_opcode 0x11 then 0x06 on consecutive cycles; rs1=1, rs2=2, wr_en=1; issue_count=2.
- LOAD r3 (0x6980), then ADD r4,r3 (0x4630) → one cycle with dec_valid=0 between them; ADD issues at t+2. Repeat with ADD r4,r2 (0x4620) → no bubble.
- MUL r7,r1 (0x8790) → dec_opcode 0x21, wr_addr=7, wr_en=1, wr2_en=1. Word 0xFC00 → dec_opcode 0x3F, dec_illegal=1, wr_en=0.
- Hold exec_ready=0 for 3 cycles with SUB in the holding register → outputs stable and fetch_ready=0; release → one transfer and issue_count+1.
- Assert flush while JEQ (0x0800) transfers and fetch_valid=1 → fetch word discarded; next cycle dec_valid=0 and fetch_ready=1.
- STP (0x9C00) transfers → halted=1 and fetch_ready=0 permanently, and flush has no effect; assert reset → halted=0 and issue_count=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Decode/issue stage: registers fetched words into IR', decodes them,
// applies the load-use bubble, flush and STP halt.
module instr_decode_stage #(
    parameter bit LOAD_USE_BUBBLE = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_valid_i,
    input  logic [15:0] fetch_instruction_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    input  logic        exec_ready_i,
    output logic        dec_valid_o,
    output logic [15:0] dec_instruction_o,
    output logic [5:0]  dec_opcode_o,
    output logic [2:0]  dec_rs1_addr_o,
    output logic [2:0]  dec_rs2_addr_o,
    output logic [2:0]  dec_wr_addr_o,
    output logic        dec_wr_en_o,
    output logic        dec_wr2_en_o,
    output logic        dec_is_branch_o,
    output logic        dec_illegal_o,
    output logic        halted_o,
    output logic [15:0] issue_count_o
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [5:0] OP_STP = 6'h27;

    state_t      state_q;
    logic        out_valid_q;
    logic [15:0] instr_q;
    logic [5:0]  opc_q;
    logic        wr_en_q, wr2_en_q, br_q, ill_q;
    logic        rs1_use_q, rs2_use_q, is_load_q;
    logic        load_pending_q;
    logic [2:0]  load_rd_q;
    logic [15:0] cnt_q;

    logic [5:0]  raw;
    logic [5:0]  opc_d;
    logic        ill_d, wr_en_d, wr2_en_d, br_d;
    logic        rs1_use_d, rs2_use_d, is_load_d;

    logic        run, hazard, transfer, capture;

    // Decode the incoming fetch word so the holding register captures ready fields
    always_comb begin
        raw       = fetch_instruction_i[15:10];
        ill_d     = raw > 6'h38;
        opc_d     = ill_d ? 6'h3F : raw;
        wr_en_d   = ~ill_d & ((raw == 6'h03)
                  | (raw >= 6'h06 && raw <= 6'h0E)
                  | (raw >= 6'h10 && raw <= 6'h14)
                  | (raw == 6'h17) | (raw == 6'h18)
                  | (raw == 6'h1A) | (raw == 6'h1B)
                  | (raw >= 6'h1D && raw <= 6'h22)
                  | (raw == 6'h25));
        wr2_en_d  = (raw == 6'h21);
        br_d      = (raw == 6'h00) | (raw == 6'h01) | (raw == 6'h02)
                  | (raw == 6'h23) | (raw == 6'h24) | (raw == 6'h26)
                  | (raw == 6'h37) | (raw == 6'h38);
        is_load_d = (raw == 6'h1A) | (raw == 6'h1B) | (raw == 6'h25);
        rs2_use_d = (raw >= 6'h11 && raw <= 6'h16) | (raw == 6'h19)
                  | (raw >= 6'h1C && raw <= 6'h21);
        rs1_use_d = ~ill_d & ~((raw == 6'h0A)
                  | (raw >= 6'h26 && raw <= 6'h36));
    end

    // Handshake, interlock and transfer qualification
    always_comb begin
        run      = (state_q == RUN);
        hazard   = LOAD_USE_BUBBLE & load_pending_q & out_valid_q
                 & ((rs1_use_q & (instr_q[9:7] == load_rd_q))
                  | (rs2_use_q & (instr_q[6:4] == load_rd_q)));
        dec_valid_o   = out_valid_q & ~hazard & run;
        transfer      = dec_valid_o & exec_ready_i;
        fetch_ready_o = run & ~flush_i & (~out_valid_q | transfer);
        capture       = fetch_valid_i & fetch_ready_o;
    end

    // Holding register, interlock tracking, issue counter and run/halt state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= RUN;
            out_valid_q    <= 1'b0;
            instr_q        <= '0;
            opc_q          <= '0;
            wr_en_q        <= 1'b0;
            wr2_en_q       <= 1'b0;
            br_q           <= 1'b0;
            ill_q          <= 1'b0;
            rs1_use_q      <= 1'b0;
            rs2_use_q      <= 1'b0;
            is_load_q      <= 1'b0;
            load_pending_q <= 1'b0;
            load_rd_q      <= '0;
            cnt_q          <= '0;
        end else begin
            if (transfer)
                cnt_q <= cnt_q + 16'd1;
            if (run) begin
                load_pending_q <= transfer & is_load_q & ~flush_i;
                if (transfer)
                    load_rd_q <= instr_q[9:7];
                if (transfer && opc_q == OP_STP)
                    state_q <= HALT;
                if (flush_i) begin
                    out_valid_q <= 1'b0;
                end else if (capture) begin
                    out_valid_q <= 1'b1;
                    instr_q     <= fetch_instruction_i;
                    opc_q       <= opc_d;
                    wr_en_q     <= wr_en_d;
                    wr2_en_q    <= wr2_en_d;
                    br_q        <= br_d;
                    ill_q       <= ill_d;
                    rs1_use_q   <= rs1_use_d;
                    rs2_use_q   <= rs2_use_d;
                    is_load_q   <= is_load_d;
                end else if (transfer) begin
                    out_valid_q <= 1'b0;
                end
            end else begin
                load_pending_q <= 1'b0;
            end
        end
    end

    assign dec_instruction_o = instr_q;
    assign dec_opcode_o      = opc_q;
    assign dec_rs1_addr_o    = instr_q[9:7];
    assign dec_wr_addr_o     = instr_q[9:7];
    assign dec_rs2_addr_o    = instr_q[6:4];
    assign dec_wr_en_o       = wr_en_q;
    assign dec_wr2_en_o      = wr2_en_q;
    assign dec_is_branch_o   = br_q;
    assign dec_illegal_o     = ill_q;
    assign halted_o          = (state_q == HALT);
    assign issue_count_o     = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed testbench for instr_decode_stage.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [15:0] fetch_instruction;
    logic        fetch_ready;
    logic        flush;
    logic        exec_ready;
    logic        dec_valid;
    logic [15:0] dec_instruction;
    logic [5:0]  dec_opcode;
    logic [2:0]  dec_rs1_addr, dec_rs2_addr, dec_wr_addr;
    logic        dec_wr_en, dec_wr2_en, dec_is_branch, dec_illegal;
    logic        halted;
    logic [15:0] issue_count;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    instr_decode_stage #(.LOAD_USE_BUBBLE(1'b1)) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .fetch_valid_i      (fetch_valid),
        .fetch_instruction_i(fetch_instruction),
        .fetch_ready_o      (fetch_ready),
        .flush_i            (flush),
        .exec_ready_i       (exec_ready),
        .dec_valid_o        (dec_valid),
        .dec_instruction_o  (dec_instruction),
        .dec_opcode_o       (dec_opcode),
        .dec_rs1_addr_o     (dec_rs1_addr),
        .dec_rs2_addr_o     (dec_rs2_addr),
        .dec_wr_addr_o      (dec_wr_addr),
        .dec_wr_en_o        (dec_wr_en),
        .dec_wr2_en_o       (dec_wr2_en),
        .dec_is_branch_o    (dec_is_branch),
        .dec_illegal_o      (dec_illegal),
        .halted_o           (halted),
        .issue_count_o      (issue_count)
    );

    task automatic drive(input logic fv, input logic [15:0] ins,
                         input logic er, input logic fl);
        @(negedge clk);
        fetch_valid       = fv;
        fetch_instruction = ins;
        exec_ready        = er;
        flush             = fl;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_valid = 1'b0;
        fetch_instruction = 16'h0;
        exec_ready = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({dec_valid, dec_opcode, dec_instruction, dec_wr_en, dec_wr2_en,
             dec_is_branch, dec_illegal, halted} !== 27'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b op=%h ins=%h br=%b h=%b want all zero",
                     dec_valid, dec_opcode, dec_instruction, dec_is_branch, halted);
        end
        vectors++;
        if (issue_count !== 16'h0 || fetch_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: cnt=%h rdy=%b want cnt=0000 rdy=1",
                     issue_count, fetch_ready);
        end
        exp_cnt = 16'h0;
    endtask

    task automatic test_stream();
        drive(1'b1, 16'h44A0, 1'b1, 1'b0);
        drive(1'b1, 16'h1A80, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h11 || dec_rs1_addr !== 3'd1
            || dec_rs2_addr !== 3'd2 || dec_wr_addr !== 3'd1 || dec_wr_en !== 1'b1
            || fetch_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_add: v=%b op=%h rs1=%0d rs2=%0d wa=%0d we=%b rdy=%b want 1 11 1 2 1 1 1",
                     dec_valid, dec_opcode, dec_rs1_addr, dec_rs2_addr,
                     dec_wr_addr, dec_wr_en, fetch_ready);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h06 || dec_wr_addr !== 3'd5
            || dec_wr_en !== 1'b1 || issue_count !== 16'd1) begin
            miscompares++;
            $display("FAIL stream_inv: v=%b op=%h wa=%0d we=%b cnt=%0d want 1 06 5 1 1",
                     dec_valid, dec_opcode, dec_wr_addr, dec_wr_en, issue_count);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        exp_cnt = 16'd2;
        vectors++;
        if (dec_valid !== 1'b0 || issue_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL stream_end: v=%b cnt=%0d want v=0 cnt=%0d",
                     dec_valid, issue_count, exp_cnt);
        end
    endtask

    task automatic test_load_use();
        // dependent consumer: one bubble
        drive(1'b1, 16'h6980, 1'b1, 1'b0);
        drive(1'b1, 16'h4630, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h1A || dec_wr_addr !== 3'd3) begin
            miscompares++;
            $display("FAIL lu_load: v=%b op=%h wa=%0d want 1 1a 3",
                     dec_valid, dec_opcode, dec_wr_addr);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b0 || fetch_ready !== 1'b0 || dec_opcode !== 6'h11) begin
            miscompares++;
            $display("FAIL lu_bubble: v=%b rdy=%b op=%h want v=0 rdy=0 op=11",
                     dec_valid, fetch_ready, dec_opcode);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h11 || dec_rs2_addr !== 3'd3) begin
            miscompares++;
            $display("FAIL lu_issue: v=%b op=%h rs2=%0d want 1 11 3",
                     dec_valid, dec_opcode, dec_rs2_addr);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd2;
        vectors++;
        if (dec_valid !== 1'b0 || issue_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL lu_count: v=%b cnt=%0d want v=0 cnt=%0d",
                     dec_valid, issue_count, exp_cnt);
        end
        // independent consumer: no bubble
        drive(1'b1, 16'h6980, 1'b1, 1'b0);
        drive(1'b1, 16'h4620, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h11 || dec_rs2_addr !== 3'd2
            || dec_rs1_addr !== 3'd4) begin
            miscompares++;
            $display("FAIL lu_nobubble: v=%b op=%h rs1=%0d rs2=%0d want 1 11 4 2",
                     dec_valid, dec_opcode, dec_rs1_addr, dec_rs2_addr);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd2;
        vectors++;
        if (issue_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL lu_nb_count: cnt=%0d want %0d", issue_count, exp_cnt);
        end
    endtask

    task automatic test_mul_illegal();
        drive(1'b1, 16'h8790, 1'b1, 1'b0);
        drive(1'b1, 16'hFC00, 1'b1, 1'b0);
        vectors++;
        if (dec_opcode !== 6'h21 || dec_wr_addr !== 3'd7 || dec_wr_en !== 1'b1
            || dec_wr2_en !== 1'b1 || dec_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL mul: op=%h wa=%0d we=%b we2=%b ill=%b want 21 7 1 1 0",
                     dec_opcode, dec_wr_addr, dec_wr_en, dec_wr2_en, dec_illegal);
        end
        drive(1'b1, 16'hE000, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h3F || dec_illegal !== 1'b1
            || dec_wr_en !== 1'b0 || dec_wr2_en !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_fc00: v=%b op=%h ill=%b we=%b we2=%b want 1 3f 1 0 0",
                     dec_valid, dec_opcode, dec_illegal, dec_wr_en, dec_wr2_en);
        end
        drive(1'b1, 16'hE400, 1'b1, 1'b0);
        vectors++;
        if (dec_opcode !== 6'h38 || dec_illegal !== 1'b0 || dec_is_branch !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_38: op=%h ill=%b br=%b want 38 0 1",
                     dec_opcode, dec_illegal, dec_is_branch);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (dec_opcode !== 6'h3F || dec_illegal !== 1'b1 || dec_is_branch !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_39: op=%h ill=%b br=%b want 3f 1 0",
                     dec_opcode, dec_illegal, dec_is_branch);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd4;
        vectors++;
        if (issue_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL mul_count: cnt=%0d want %0d", issue_count, exp_cnt);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 16'h4990, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h1A80, 1'b0, 1'b0);
            vectors++;
            if (dec_valid !== 1'b1 || dec_opcode !== 6'h12
                || dec_instruction !== 16'h4990 || fetch_ready !== 1'b0
                || issue_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL stall_%0d: v=%b op=%h ins=%h rdy=%b cnt=%0d want 1 12 4990 0 %0d",
                         i, dec_valid, dec_opcode, dec_instruction, fetch_ready,
                         issue_count, exp_cnt);
            end
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if (fetch_ready !== 1'b1 || dec_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: rdy=%b v=%b want 1 1", fetch_ready, dec_valid);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        vectors++;
        if (dec_valid !== 1'b0 || issue_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL stall_count: v=%b cnt=%0d want 0 %0d",
                     dec_valid, issue_count, exp_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0800, 1'b1, 1'b0);
        drive(1'b1, 16'h4630, 1'b1, 1'b1);
        vectors++;
        if (dec_valid !== 1'b1 || dec_is_branch !== 1'b1 || fetch_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_jeq: v=%b br=%b rdy=%b want 1 1 0",
                     dec_valid, dec_is_branch, fetch_ready);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        vectors++;
        if (dec_valid !== 1'b0 || fetch_ready !== 1'b1 || issue_count !== exp_cnt
            || dec_opcode !== 6'h02) begin
            miscompares++;
            $display("FAIL flush_after: v=%b rdy=%b cnt=%0d op=%h want 0 1 %0d 02",
                     dec_valid, fetch_ready, issue_count, dec_opcode, exp_cnt);
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 16'h9C00, 1'b1, 1'b0);
        drive(1'b1, 16'h44A0, 1'b1, 1'b0);
        vectors++;
        if (dec_valid !== 1'b1 || dec_opcode !== 6'h27 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_stp: v=%b op=%h h=%b want 1 27 0",
                     dec_valid, dec_opcode, halted);
        end
        drive(1'b1, 16'h44A0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        vectors++;
        if (halted !== 1'b1 || fetch_ready !== 1'b0 || dec_valid !== 1'b0
            || issue_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL halt_enter: h=%b rdy=%b v=%b cnt=%0d want 1 0 0 %0d",
                     halted, fetch_ready, dec_valid, issue_count, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h44A0, 1'b1, (i == 1));
            vectors++;
            if (halted !== 1'b1 || fetch_ready !== 1'b0 || dec_valid !== 1'b0
                || issue_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL halt_hold_%0d: h=%b rdy=%b v=%b cnt=%0d want 1 0 0 %0d",
                         i, halted, fetch_ready, dec_valid, issue_count, exp_cnt);
            end
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (halted !== 1'b0 || issue_count !== 16'h0 || dec_opcode !== 6'h0
            || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset: h=%b cnt=%0d op=%h v=%b want 0 0 00 0",
                     halted, issue_count, dec_opcode, dec_valid);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        vectors++;
        if (fetch_ready !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_rerun: rdy=%b h=%b want 1 0", fetch_ready, halted);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_mul_illegal();
        test_stall();
        test_flush();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
